// File: rtl/apb_pkg.sv
// Shared APB types and constants: FSM state encoding,
// default bus widths and completer read-select addresses.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam logic [1:0] RS_ERR_STATUS = 2'd0;
  localparam logic [1:0] RS_PAYLOAD_0  = 2'd1;
  localparam logic [1:0] RS_PAYLOAD_1  = 2'd2;
  localparam logic [1:0] RS_DATA_SIZE  = 2'd3;

endpackage

// File: rtl/apb_requester_if.sv
// Command/response port plus APB bus of the requester.
// master = requester side, slave = control logic and completer.
interface apb_requester_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          psel_x;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output psel_x, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  psel_x, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_requester.sv
// APB requester FSM: one command in flight, one-cycle response pulse.
// Define APB_REQUESTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             pclk,
  input logic             preset,
  apb_requester_if.master bus
);

  apb_state_t state_q, state_d;

  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic accept;
  logic done;
  logic tmo;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == ACCESS && !bus.pready)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // pready in the limit cycle wins over the abort
  assign tmo = (state_q == ACCESS) && !bus.pready &&
               (cnt_q == CW'(TIMEOUT_CYCLES));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  assign bus.req_ready = (state_q == IDLE) ||
                         (state_q == ACCESS && bus.pready);
  assign accept = bus.req_valid && bus.req_ready;
  assign done   = (state_q == ACCESS) && bus.pready;

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvalid_d = done || tmo;
    rerr_d   = done ? bus.pslverr : tmo;
    rdata_d  = rdata_q;
    if (done && !pwrite_q)
      rdata_d = bus.prdata;
    if (accept) begin
      pwrite_d = bus.req_write;
      paddr_d  = bus.req_addr;
      pwdata_d = bus.req_wdata;
    end
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done)     state_d = accept ? SETUP : IDLE;
        else if (tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.psel_x     = (state_q != IDLE);
  assign bus.penable    = (state_q == ACCESS);
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB master-side requester FSM; sits directly upstream of the APB read/write completer slaves.
- Accepts single read/write commands from an internal control port and drives psel_x/penable/pwrite/paddr/pwdata.
- Completes each transfer on pready, captures prdata/pslverr and returns a one-cycle response pulse.
- In the top level, paddr[1:0] feeds the completer's read_select.

Parameters:
- ADDR_WIDTH, 8, width of req_addr/paddr.
- DATA_WIDTH, 8, width of write/read data.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait-state cycles before abort (optional feature only); must be >= 1.

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- preset  in  1  synchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  read data (valid with resp_valid on reads).
- resp_err  out  1  slave error, or timeout.
- psel_x  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  completer ready.
- prdata  in  DATA_WIDTH  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Clock and reset: one clock, pclk. preset is synchronous and active-high.
- Reset values: state = IDLE; psel_x, penable, pwrite, resp_valid, resp_err = 0; paddr, pwdata, resp_rdata = 0.
- States:
  - IDLE: psel_x = 0, penable = 0.
  - SETUP: psel_x = 1, penable = 0.
  - ACCESS: psel_x = 1, penable = 1.
- req_ready = (state == IDLE) || (state == ACCESS && pready). Combinational from state and pready.
- Accept: req_valid && req_ready → register req_write/req_addr/req_wdata into pwrite/paddr/pwdata; next state SETUP.
- SETUP → ACCESS unconditionally after exactly one cycle.
- ACCESS with pready = 0: stay in ACCESS. All APB outputs are held stable across wait states.
- ACCESS with pready = 1: transfer completes.
  - Next state is SETUP if a new command is accepted in the same cycle (back-to-back, no IDLE gap). Otherwise next state is IDLE.
- Response, on the cycle after completion:
  - resp_valid = 1 for exactly one cycle.
  - resp_err = pslverr sampled at completion.
  - resp_rdata = prdata sampled at completion if !pwrite; otherwise resp_rdata holds its previous value.
  - No response backpressure.
- Latency: accept at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2. With zero wait states, resp_valid is high in cycle N+3.
- APB outputs in IDLE:
  - paddr/pwdata/pwrite retain their last values.
  - psel_x and penable are the only qualifiers.
- preset asserted mid-transfer: at the next edge, state = IDLE and all outputs return to reset values. The in-flight transfer produces no resp_valid.
- pslverr is ignored unless psel_x && penable && pready.

Optional Feature:
- Macro: APB_REQUESTER_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer aborts: next state IDLE, resp_valid = 1 with resp_err = 1, resp_rdata unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - pready = 1 in the same cycle as the limit is reached wins, giving normal completion.
- Without the macro: no counter logic; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg:
  - State enum apb_state_t {IDLE, SETUP, ACCESS}.
  - Default ADDR_WIDTH/DATA_WIDTH constants.
  - Read-select address constants: 0 = ERR_STATUS, 1 = PAYLOAD_0, 2 = PAYLOAD_1, 3 = DATA_SIZE.
- Single module. The optional timeout counter may be a sub-module apb_wait_timer; keep it inline unless it is reused.

Test Plan:
- Read, zero wait:
  - Stimulus: req addr 0x01, pready held 1, prdata 0xA5.
  - Response: psel_x rises N+1, penable N+2; resp_valid in N+3 with resp_rdata 0xA5, resp_err 0.
- Write, 3 wait states:
  - Stimulus: req addr 0x02, wdata 0x3C.
  - Response: penable high 4 cycles; paddr 0x02 and pwdata 0x3C stable throughout; resp_valid once, resp_rdata unchanged.
- Back-to-back:
  - Stimulus: req_valid held with read 0x00 then read 0x03; pready = 1.
  - Response: ACCESS of the first is followed directly by SETUP of the second, psel_x never drops; two resp_valid pulses 2 cycles apart.
- Slave error:
  - Stimulus: read with pslverr = 1 at completion.
  - Response: resp_err = 1 on resp_valid. A subsequent clean read gives resp_err = 0.
- Reset mid-ACCESS:
  - Stimulus: assert preset during a wait state.
  - Response: next cycle psel_x = penable = 0, state IDLE, no resp_valid; the next request completes normally.
- Timeout (APB_REQUESTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4):
  - Stimulus: pready held 0.
  - Response: abort after 4 wait cycles, resp_valid = 1 with resp_err = 1, psel_x = 0 the following cycle.
